// File: rtl/morse_tx_queue.sv
// Queued Morse keyer for letters A-Z: a small letter FIFO feeds a pattern
// serialiser that keys one element per TICK_DIV-cycle unit, then a LETTER_GAP pause.
module morse_tx_queue #(
  parameter int TICK_DIV   = 25000000,
  parameter int FIFO_DEPTH = 4,
  parameter int LETTER_GAP = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [4:0] in_letter,
  output logic       in_ready,
  input  logic       abort,
  output logic       dot_dash_out,
  output logic       new_bit_out,
  output logic       busy,
  output logic       invalid_pulse
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int GW = (LETTER_GAP > 0) ? $clog2(LETTER_GAP + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(LETTER_GAP - 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [15:0] bits;
    logic [3:0]  len;
  } pat_t;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                     state;
  logic [FIFO_DEPTH-1:0][4:0] mem;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [AW:0]                count;
  logic [15:0]                shreg;
  logic [3:0]                 rem;
  logic [TW-1:0]              tick;
  logic [GW-1:0]              gap_left;
  logic                       push_hs, push_store, pop;
  pat_t                       head;

  // Patterns are written right-aligned with their length, then left-aligned here.
  function automatic pat_t lookup(input logic [4:0] c);
    logic [15:0] raw;
    logic [3:0]  l;
    pat_t        p;
    raw = 16'b0;
    l   = 4'd1;
    case (c)
      5'd0:  begin raw = 16'b10111;         l = 4'd5;  end
      5'd1:  begin raw = 16'b111010101;     l = 4'd9;  end
      5'd2:  begin raw = 16'b11101011101;   l = 4'd11; end
      5'd3:  begin raw = 16'b1110101;       l = 4'd7;  end
      5'd4:  begin raw = 16'b1;             l = 4'd1;  end
      5'd5:  begin raw = 16'b101011101;     l = 4'd9;  end
      5'd6:  begin raw = 16'b111011101;     l = 4'd9;  end
      5'd7:  begin raw = 16'b1010101;       l = 4'd7;  end
      5'd8:  begin raw = 16'b101;           l = 4'd3;  end
      5'd9:  begin raw = 16'b1011101110111; l = 4'd13; end
      5'd10: begin raw = 16'b111010111;     l = 4'd9;  end
      5'd11: begin raw = 16'b101110101;     l = 4'd9;  end
      5'd12: begin raw = 16'b1110111;       l = 4'd7;  end
      5'd13: begin raw = 16'b11101;         l = 4'd5;  end
      5'd14: begin raw = 16'b11101110111;   l = 4'd11; end
      5'd15: begin raw = 16'b10111011101;   l = 4'd11; end
      5'd16: begin raw = 16'b1110111010111; l = 4'd13; end
      5'd17: begin raw = 16'b1011101;       l = 4'd7;  end
      5'd18: begin raw = 16'b10101;         l = 4'd5;  end
      5'd19: begin raw = 16'b111;           l = 4'd3;  end
      5'd20: begin raw = 16'b1010111;       l = 4'd7;  end
      5'd21: begin raw = 16'b101010111;     l = 4'd9;  end
      5'd22: begin raw = 16'b101110111;     l = 4'd9;  end
      5'd23: begin raw = 16'b11101010111;   l = 4'd11; end
      5'd24: begin raw = 16'b1110101110111; l = 4'd13; end
      5'd25: begin raw = 16'b11101110101;   l = 4'd11; end
      default: begin raw = 16'b0;           l = 4'd1;  end
    endcase
    p.bits = raw << (5'd16 - {1'b0, l});
    p.len  = l;
    return p;
  endfunction

  assign in_ready   = (count < DEPTH);
  assign push_hs    = in_valid && in_ready;
  assign push_store = push_hs && !abort && (in_letter < 5'd26);
  assign pop        = (state == IDLE) && (count != '0) && !abort;
  assign head       = lookup(mem[rd_ptr]);

  always_ff @(posedge clock) begin
    if (push_store) mem[wr_ptr] <= in_letter;
  end

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_store) - (AW+1)'(pop);
    end
  end

  // Abort does not clear a pending invalid indication; only reset does.
  always_ff @(posedge clock) begin
    if (reset) invalid_pulse <= 1'b0;
    else       invalid_pulse <= push_hs && (in_letter > 5'd25);
  end

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      state        <= IDLE;
      shreg        <= '0;
      rem          <= '0;
      tick         <= '0;
      gap_left     <= '0;
      dot_dash_out <= 1'b0;
      new_bit_out  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tick         <= '0;
          dot_dash_out <= 1'b0;
          new_bit_out  <= 1'b0;
          if (count != '0) begin
            shreg        <= head.bits;
            rem          <= head.len;
            dot_dash_out <= head.bits[15];
            new_bit_out  <= 1'b1;
            busy         <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          if (tick == TICK_MAX) begin
            tick        <= '0;
            new_bit_out <= 1'b1;
            if (rem == 4'd1) begin
              dot_dash_out <= 1'b0;
              gap_left     <= GAP_INIT;
              state        <= GAP;
            end else begin
              shreg        <= {shreg[14:0], 1'b0};
              rem          <= rem - 4'd1;
              dot_dash_out <= shreg[14];
            end
          end else begin
            tick        <= tick + 1'b1;
            new_bit_out <= 1'b0;
          end
        end
        GAP: begin
          dot_dash_out <= 1'b0;
          if (tick == TICK_MAX) begin
            tick <= '0;
            if (gap_left == '0) begin
              new_bit_out <= 1'b0;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              gap_left    <= gap_left - 1'b1;
              new_bit_out <= 1'b1;
            end
          end else begin
            tick        <= tick + 1'b1;
            new_bit_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_tx_queue.sv
// Directed bench for morse_tx_queue with TICK_DIV=4, FIFO_DEPTH=4, LETTER_GAP=3.
module tb_morse_tx_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [4:0] in_letter = 5'd0;
  logic       in_ready;
  logic       abort = 1'b0;
  logic       dot_dash_out, new_bit_out, busy, invalid_pulse;

  int n_chk = 0;
  int n_fail = 0;

  morse_tx_queue #(.TICK_DIV(4), .FIFO_DEPTH(4), .LETTER_GAP(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_letter(in_letter),
    .in_ready(in_ready), .abort(abort), .dot_dash_out(dot_dash_out),
    .new_bit_out(new_bit_out), .busy(busy), .invalid_pulse(invalid_pulse)
  );

  always #5 clock = ~clock;

  // Per-letter capture: every busy cycle's dot/new_bit shifted into a word.
  logic [63:0] dotq[$];
  logic [63:0] nbq[$];
  int          bcq[$];
  int          gapq[$];
  logic [63:0] dot_sh, nb_sh;
  int          bc, idle_run, busy_total, stray_dot, stray_nb;
  bit          in_let, had;

  initial begin
    dot_sh = '0; nb_sh = '0; bc = 0; idle_run = 0; busy_total = 0;
    stray_dot = 0; stray_nb = 0; in_let = 0; had = 0;
  end

  always @(negedge clock) begin
    if (busy) begin
      if (!in_let) begin
        in_let = 1;
        if (had) gapq.push_back(idle_run);
        dot_sh = '0; nb_sh = '0; bc = 0;
      end
      dot_sh = {dot_sh[62:0], dot_dash_out};
      nb_sh  = {nb_sh[62:0], new_bit_out};
      bc++;
      busy_total++;
    end else begin
      if (in_let) begin
        in_let = 0;
        dotq.push_back(dot_sh);
        nbq.push_back(nb_sh);
        bcq.push_back(bc);
        had = 1;
        idle_run = 0;
      end
      idle_run++;
      if (dot_dash_out) stray_dot++;
      if (new_bit_out)  stray_nb++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    dotq.delete(); nbq.delete(); bcq.delete(); gapq.delete();
    had = 0;
  endtask

  task automatic push(input logic [4:0] c, output int stall);
    @(negedge clock);
    in_valid  = 1'b1;
    in_letter = c;
    stall = 0;
    while (!in_ready && stall < 500) begin
      @(negedge clock);
      stall++;
    end
    if (stall >= 500) chk("push_timeout", 64'(stall), 64'd0);
    @(posedge clock);
    #1;
  endtask

  // Units are expanded to 4 cycles each; new_bit marks a unit's first cycle.
  task automatic chk_letter(input string tag, input logic [15:0] u, input int n);
    logic [63:0] d, nb, gd, gn;
    int w, gb;
    d = '0; nb = '0; w = 0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        d  = {d[62:0], u[n-1-i]};
        nb = {nb[62:0], (k == 0)};
      end
    while (dotq.size() == 0 && w < 2000) begin
      @(negedge clock);
      w++;
    end
    if (dotq.size() == 0) begin
      chk({tag, "_timeout"}, 64'(w), 64'd0);
    end else begin
      gd = dotq.pop_front(); gn = nbq.pop_front(); gb = bcq.pop_front();
      chk({tag, "_dot"}, gd, d);
      chk({tag, "_nb"}, gn, nb);
      chk({tag, "_busy"}, 64'(gb), 64'(n * 4));
    end
  endtask

  task automatic mid_q_kill(input string tag, input bit use_reset);
    int st, base;
    clear_log();
    push(5'd16, st);
    push(5'd4, st);
    push(5'd19, st);
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk({tag, "_middash"}, 64'(dot_dash_out), 64'd1);
    @(negedge clock);
    if (use_reset) reset = 1'b1; else abort = 1'b1;
    in_valid  = 1'b1;
    in_letter = 5'd0;
    @(posedge clock);
    #1;
    reset = 1'b0; abort = 1'b0; in_valid = 1'b0;
    chk({tag, "_dot"}, 64'(dot_dash_out), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_nb"}, 64'(new_bit_out), 64'd0);
    base = busy_total;
    repeat (40) @(posedge clock);
    #1;
    chk({tag, "_quiet"}, 64'(busy_total - base), 64'd0);
    clear_log();
  endtask

  initial begin
    int st, base;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dot", 64'(dot_dash_out), 64'd0);
    chk("rst_nb", 64'(new_bit_out), 64'd0);
    chk("rst_inv", 64'(invalid_pulse), 64'd0);

    // E: queued at E0, keyed from E1
    push(5'd4, st);
    in_valid = 1'b0;
    chk("e_e0_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    chk("e_e1_busy", 64'(busy), 64'd1);
    chk("e_e1_dot", 64'(dot_dash_out), 64'd1);
    chk("e_e1_nb", 64'(new_bit_out), 64'd1);
    @(posedge clock); #1;
    chk("e_e2_nb", 64'(new_bit_out), 64'd0);
    chk_letter("e", 16'b1000, 4);

    push(5'd0, st);
    in_valid = 1'b0;
    chk_letter("a", 16'b10111000, 8);
    repeat (4) @(posedge clock);

    // Invalid code: pulse next cycle, nothing stored
    base = busy_total;
    push(5'd27, st);
    in_valid = 1'b0;
    chk("inv_pulse", 64'(invalid_pulse), 64'd1);
    @(posedge clock); #1;
    chk("inv_pulse_end", 64'(invalid_pulse), 64'd0);
    repeat (10) @(posedge clock); #1;
    chk("inv_no_busy", 64'(busy_total - base), 64'd0);
    chk("inv_ready", 64'(in_ready), 64'd1);

    // A, B, C back to back
    clear_log();
    push(5'd0, st);
    push(5'd1, st);
    push(5'd2, st);
    in_valid = 1'b0;
    chk_letter("abc_a", 16'b10111000, 8);
    chk_letter("abc_b", 16'b111010101000, 12);
    chk_letter("abc_c", 16'b11101011101000, 14);
    chk("abc_gapcnt", 64'(gapq.size()), 64'd2);
    while (gapq.size() > 0) chk("abc_idle1", 64'(gapq.pop_front()), 64'd1);
    repeat (4) @(posedge clock);

    // Six pushes while the first is sent: the sixth stalls but is kept
    clear_log();
    push(5'd4, st);  chk("q1_stall", 64'(st), 64'd0);
    push(5'd19, st); chk("q2_stall", 64'(st), 64'd0);
    push(5'd8, st);
    push(5'd18, st);
    push(5'd13, st); chk("q5_stall", 64'(st), 64'd0);
    push(5'd0, st);  chk("q6_held", 64'(st > 0), 64'd1);
    in_valid = 1'b0;
    chk_letter("q_e", 16'b1000, 4);
    chk_letter("q_t", 16'b111000, 6);
    chk_letter("q_i", 16'b101000, 6);
    chk_letter("q_s", 16'b10101000, 8);
    chk_letter("q_n", 16'b11101000, 8);
    chk_letter("q_a", 16'b10111000, 8);
    repeat (4) @(posedge clock);

    mid_q_kill("abort", 1'b0);
    mid_q_kill("reset", 1'b1);

    chk("stray_dot", 64'(stray_dot), 64'd0);
    chk("stray_nb", 64'(stray_nb), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
